// File: rtl/tff_arb_pkg.sv
// Shared definitions for the round-robin T flip-flop arbiter: FSM state encoding.
package tff_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/tff_bank.sv
// W-bit bank of T flip-flops with synchronous active-high reset; a 1 on t[i] flips q[i].
module tff_bank #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] t,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_q ^ t;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter granting one requester per two cycles the right to toggle a shared
// T flip-flop bank with its mask; counts completed grants.
module tff_toggle_arbiter
    import tff_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] mask,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    output logic [W-1:0]       q,
    output logic [CNT_W-1:0]   toggle_cnt
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_win;
    logic [IDX_W-1:0] w_win;
    logic [IDX_W:0]   w_sum;
    logic             w_found;
    logic             w_start;
    logic [W-1:0]     r_mask;
    logic [W-1:0]     w_mask_sel;
    logic [W-1:0]     w_t;
    logic [N_REQ-1:0] r_gnt;
    logic [CNT_W-1:0] r_cnt;

    // Scan requesters starting at the pointer, wrapping modulo N_REQ; first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            end
            if (!w_found && req[w_sum[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[IDX_W-1:0];
            end
        end
    end

    assign w_mask_sel = mask[w_win*W +: W];

    always_comb begin
        w_state_nxt = r_state;
        w_t         = '0;
        case (r_state)
            IDLE: begin
                if (en && w_found) begin
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                w_state_nxt = IDLE;
                w_t         = r_mask;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_start = (r_state == IDLE) && (w_state_nxt == GRANT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt <= '0;
            r_cnt <= '0;
            r_ptr <= '0;
        end else if (w_start) begin
            r_gnt <= N_REQ'(1) << w_win;
        end else if (r_state == GRANT) begin
            r_gnt <= '0;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_win == IDX_W'(N_REQ-1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_win + 1'b1;
            end
        end
    end

    // Winner and its mask are captured at grant so later mask changes are ignored.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_win  <= w_win;
            r_mask <= w_mask_sel;
        end
    end

    tff_bank #(
        .W(W)
    ) u_bank (
        .clk  (clk),
        .reset(reset),
        .t    (w_t),
        .q    (q)
    );

    assign gnt        = r_gnt;
    assign busy       = (r_state == GRANT);
    assign toggle_cnt = r_cnt;

endmodule
